// File: rtl/bram_rd_arb.sv
// Round-robin arbiter sharing one BRAM read port among N_REQ requesters.
// Writes pass straight through; each requester holds one read in flight.
module bram_rd_arb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int N_REQ = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*AW-1:0]    req_addr,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [N_REQ*WIDTH-1:0] rsp_data,
  input  logic [N_REQ-1:0]       rsp_ready,
  input  logic                   wr_valid,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   bram_we,
  output logic [AW-1:0]          bram_waddr,
  output logic [WIDTH-1:0]       bram_wdata,
  output logic [AW-1:0]          bram_raddr,
  input  logic [WIDTH-1:0]       bram_rdata
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gid;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    tag_id;
  logic             tag_v;
  logic             found;
  logic [AW-1:0]    raddr_q;

  assign bram_we    = wr_valid;
  assign bram_waddr = wr_addr;
  assign bram_wdata = wr_data;
  assign req_ready  = grant;

  always_comb begin
    busy = '0;
    for (int i = 0; i < N_REQ; i++) begin
      busy[i] = (tag_v && tag_id == IW'(i)) || rsp_valid[i];
    end
  end

  assign elig = req_valid & ~busy & {N_REQ{~reset}};

  // Visit slots in order last_grant+1, +2, ... and take the first eligible.
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && elig[j] &&
            ((int'(last_grant) + k) % N_REQ) == j) begin
          found    = 1'b1;
          gid      = IW'(j);
          grant[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bram_raddr = raddr_q;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant[j]) begin
        bram_raddr = req_addr[j*AW +: AW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= IW'(N_REQ - 1);
      tag_v      <= 1'b0;
      tag_id     <= '0;
      raddr_q    <= '0;
      rsp_valid  <= '0;
    end else begin
      tag_v  <= found;
      tag_id <= gid;
      if (found) begin
        last_grant <= gid;
        raddr_q    <= bram_raddr;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_v && tag_id == IW'(i)) begin
          rsp_valid[i] <= 1'b1;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_v && tag_id == IW'(i)) begin
        rsp_data[i*WIDTH +: WIDTH] <= bram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bram_rd_arb.sv
// Directed and random bench for bram_rd_arb with a read-first BRAM model.
// Three requesters; contention scenarios drive only requesters 0 and 1.
module tb_bram_rd_arb;

  localparam int N = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_addr;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [N*32-1:0] rsp_data;
  logic [N-1:0]  rsp_ready;
  logic          wr_valid;
  logic [7:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          bram_we;
  logic [7:0]    bram_waddr;
  logic [31:0]   bram_wdata;
  logic [7:0]    bram_raddr;
  logic [31:0]   bram_rdata;
  logic [31:0]   mem [0:255];

  int pass_cnt = 0;
  int total = 0;

  bram_rd_arb #(.WIDTH(32), .DEPTH(256), .N_REQ(N)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .bram_we(bram_we),
    .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .bram_raddr(bram_raddr), .bram_rdata(bram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    bram_rdata <= mem[bram_raddr];
    if (bram_we) mem[bram_waddr] <= bram_wdata;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    rsp_ready = '1;
    wr_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic write(input logic [7:0] a, input logic [31:0] d);
    idle();
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    req_valid = '1;
    req_addr  = {8'd7, 8'd6, 8'd5};
    step();
    #1;
    total++;
    if (req_ready !== 3'b000)
      $display("FAIL rst_ready got=%b exp=000", req_ready);
    else pass_cnt++;
    total++;
    if (rsp_valid !== 3'b000)
      $display("FAIL rst_rsp_valid got=%b exp=000", rsp_valid);
    else pass_cnt++;
    total++;
    if (bram_raddr !== 8'd0)
      $display("FAIL rst_raddr got=%0d exp=0", bram_raddr);
    else pass_cnt++;
    step();
    reset = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b001)
      $display("FAIL rst_first_grant got=%b exp=001", req_ready);
    else pass_cnt++;
    step();
    idle();
  endtask

  task automatic test_single();
    do_reset();
    wr_valid = 1'b1;
    wr_addr  = 8'd5;
    wr_data  = 32'hA5A5_0001;
    #1;
    total++;
    if ({bram_we, bram_waddr, bram_wdata} !== {1'b1, 8'd5, 32'hA5A5_0001})
      $display("FAIL wr_pass got=%b/%0d/%h exp=1/5/a5a50001",
               bram_we, bram_waddr, bram_wdata);
    else pass_cnt++;
    step();
    wr_valid  = 1'b0;
    req_valid = 3'b001;
    req_addr  = {8'd0, 8'd0, 8'd5};
    #1;
    total++;
    if (req_ready !== 3'b001 || bram_raddr !== 8'd5)
      $display("FAIL single_grant got=%b/%0d exp=001/5",
               req_ready, bram_raddr);
    else pass_cnt++;
    step();
    req_valid = 3'b000;
    #1;
    total++;
    if (rsp_valid !== 3'b000 || bram_raddr !== 8'd5)
      $display("FAIL single_t1 got=%b/%0d exp=000/5",
               rsp_valid, bram_raddr);
    else pass_cnt++;
    step();
    #1;
    total++;
    if (rsp_valid !== 3'b001 || rsp_data[31:0] !== 32'hA5A5_0001)
      $display("FAIL single_rsp got=%b/%h exp=001/a5a50001",
               rsp_valid, rsp_data[31:0]);
    else pass_cnt++;
    step();
    #1;
    total++;
    if (rsp_valid !== 3'b000)
      $display("FAIL single_clear got=%b exp=000", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [2:0] er [0:5];
    logic [2:0] ev [0:5];
    er = '{3'b001, 3'b010, 3'b000, 3'b001, 3'b010, 3'b000};
    ev = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 3'b001};
    do_reset();
    req_valid = 3'b011;
    req_addr  = {8'd0, 8'd9, 8'd5};
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (req_ready !== er[c] || rsp_valid !== ev[c])
        $display("FAIL contention c%0d got=%b/%b exp=%b/%b",
                 c, req_ready, rsp_valid, er[c], ev[c]);
      else pass_cnt++;
      step();
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [2:0] er;
    do_reset();
    write(8'd4, 32'h44);
    write(8'd3, 32'h33);
    req_valid = 3'b011;
    req_addr  = {8'd0, 8'd3, 8'd4};
    for (int c = 0; c < 15; c++) begin
      rsp_ready = (c >= 13) ? 3'b111 : 3'b101;
      if (c == 1 || c == 14) er = 3'b010;
      else if (c % 3 == 0 && c <= 12) er = 3'b001;
      else er = 3'b000;
      #1;
      total++;
      if (req_ready !== er)
        $display("FAIL bp_grant c%0d got=%b exp=%b", c, req_ready, er);
      else pass_cnt++;
      total++;
      if (rsp_valid[1] !== (c >= 3 && c <= 13) ||
          rsp_valid[0] !== (c % 3 == 2))
        $display("FAIL bp_valid c%0d got=%b", c, rsp_valid);
      else pass_cnt++;
      if (c >= 3 && c <= 13) begin
        total++;
        if (rsp_data[63:32] !== 32'h33)
          $display("FAIL bp_hold c%0d got=%h exp=33", c, rsp_data[63:32]);
        else pass_cnt++;
      end
      if (rsp_valid[0]) begin
        total++;
        if (rsp_data[31:0] !== 32'h44)
          $display("FAIL bp_r0 c%0d got=%h exp=44", c, rsp_data[31:0]);
        else pass_cnt++;
      end
      step();
    end
    idle();
  endtask

  task automatic test_collision();
    do_reset();
    write(8'd9, 32'h11);
    req_valid = 3'b001;
    req_addr  = {8'd0, 8'd0, 8'd9};
    wr_valid  = 1'b1;
    wr_addr   = 8'd9;
    wr_data   = 32'h22;
    #1;
    total++;
    if (req_ready !== 3'b001)
      $display("FAIL coll_grant got=%b exp=001", req_ready);
    else pass_cnt++;
    step();
    idle();
    step();
    #1;
    total++;
    if (rsp_valid !== 3'b001 || rsp_data[31:0] !== 32'h11)
      $display("FAIL coll_old got=%b/%h exp=001/11",
               rsp_valid, rsp_data[31:0]);
    else pass_cnt++;
    step();
    req_valid = 3'b001;
    #1;
    total++;
    if (req_ready !== 3'b001)
      $display("FAIL coll_regrant got=%b exp=001", req_ready);
    else pass_cnt++;
    step();
    idle();
    step();
    #1;
    total++;
    if (rsp_valid !== 3'b001 || rsp_data[31:0] !== 32'h22)
      $display("FAIL coll_new got=%b/%h exp=001/22",
               rsp_valid, rsp_data[31:0]);
    else pass_cnt++;
    step();
  endtask

  task automatic test_addr_sample();
    do_reset();
    req_valid = 3'b011;
    req_addr  = {8'd0, 8'd9, 8'd4};
    #1;
    total++;
    if (req_ready !== 3'b001 || bram_raddr !== 8'd4)
      $display("FAIL samp_c0 got=%b/%0d exp=001/4", req_ready, bram_raddr);
    else pass_cnt++;
    step();
    req_valid = 3'b010;
    req_addr  = {8'd0, 8'd3, 8'd4};
    #1;
    total++;
    if (req_ready !== 3'b010 || bram_raddr !== 8'd3)
      $display("FAIL samp_c1 got=%b/%0d exp=010/3", req_ready, bram_raddr);
    else pass_cnt++;
    step();
    idle();
    step();
    #1;
    total++;
    if (rsp_valid[1] !== 1'b1 || rsp_data[63:32] !== 32'h33)
      $display("FAIL samp_rsp got=%b/%h exp=1/33",
               rsp_valid[1], rsp_data[63:32]);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 3'b001;
    req_addr  = {8'd0, 8'd0, 8'd5};
    #1;
    total++;
    if (req_ready !== 3'b001)
      $display("FAIL mid_grant got=%b exp=001", req_ready);
    else pass_cnt++;
    step();
    reset = 1'b1;
    req_valid = 3'b000;
    step();
    reset = 1'b0;
    req_valid = 3'b011;
    #1;
    total++;
    if (req_ready !== 3'b001 || rsp_valid !== 3'b000)
      $display("FAIL mid_after got=%b/%b exp=001/000",
               req_ready, rsp_valid);
    else pass_cnt++;
    step();
    req_valid = 3'b000;
    #1;
    total++;
    if (rsp_valid !== 3'b000)
      $display("FAIL mid_no_rsp got=%b exp=000", rsp_valid);
    else pass_cnt++;
    step();
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [0:15];
    logic [31:0] exp_d [0:N-1];
    logic [N-1:0] outst;
    logic [N-1:0] elig;
    int wt [0:N-1];
    int bad;
    do_reset();
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      write(8'(a), ref_mem[a]);
    end
    outst = '0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        req_addr[i*8 +: 8] = 8'($urandom_range(0, 15));
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 8'($urandom_range(0, 15));
      wr_data  = $urandom;
      #1;
      elig = req_valid & ~outst;
      bad = 0;
      if ($countones(req_ready) > 1) bad = 1;
      if ((req_ready & ~elig) != 0) bad = 1;
      if (elig != 0 && req_ready == 0) bad = 1;
      if ((rsp_valid & ~outst) != 0) bad = 1;
      for (int i = 0; i < N; i++) begin
        if (elig[i] && !req_ready[i]) wt[i]++;
        else wt[i] = 0;
        if (wt[i] > N) bad = 1;
      end
      total++;
      if (bad != 0)
        $display("FAIL rand_arb cyc%0d got=%b/%b exp_elig=%b outst=%b",
                 cyc, req_ready, rsp_valid, elig, outst);
      else pass_cnt++;
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          total++;
          if (rsp_data[i*32 +: 32] !== exp_d[i])
            $display("FAIL rand_data cyc%0d r%0d got=%h exp=%h",
                     cyc, i, rsp_data[i*32 +: 32], exp_d[i]);
          else pass_cnt++;
          outst[i] = 1'b0;
        end
        if (req_ready[i]) begin
          exp_d[i] = ref_mem[req_addr[i*8 +: 4]];
          outst[i] = 1'b1;
        end
      end
      if (wr_valid) ref_mem[wr_addr[3:0]] = wr_data;
      step();
    end
    idle();
  endtask

  initial begin
    req_addr = '0;
    wr_addr  = '0;
    wr_data  = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_collision();
    test_addr_sample();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_rd_arb.md
BRAM_RD_ARB -- requirements
Module: bram_rd_arb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 32, BRAM data width.
- DEPTH, 256, BRAM depth; AW = $clog2(DEPTH).
- N_REQ, 2, number of read requesters; legal range 2..8.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous active-high reset.
- req_valid, in, N_REQ, per-requester read request.
- req_addr, in, N_REQ x AW, per-requester read address.
- req_ready, out, N_REQ, request accepted this cycle (one-hot or zero).
- rsp_valid, out, N_REQ, per-requester response holding data.
- rsp_data, out, N_REQ x WIDTH, per-requester response data.
- rsp_ready, in, N_REQ, requester consumes its response.
- wr_valid, in, 1, write request from the single writer; always accepted.
- wr_addr, in, AW, write address.
- wr_data, in, WIDTH, write data.
- bram_we, out, 1, BRAM write enable.
- bram_waddr, out, AW, BRAM write address.
- bram_wdata, out, WIDTH, BRAM write data.
- bram_raddr, out, AW, BRAM read address.
- bram_rdata, in, WIDTH, BRAM registered read data; valid one cycle after bram_raddr.

Function
REQ-003 Write path is combinational pass-through: bram_we=wr_valid, bram_waddr=wr_addr, bram_wdata=wr_data; no arbitration, no stall.
REQ-004 Per requester i, busy_i = (read in flight for i) OR rsp_valid[i]; eligible_i = req_valid[i] AND NOT busy_i.
REQ-005 Each cycle at most one eligible requester is granted, by round-robin: search starts at (last_grant+1) mod N_REQ; the first eligible requester wins.
REQ-006 req_ready[g] is asserted combinationally in the grant cycle T for winner g only; last_grant updates to g at the end of T; with no grant, last_grant holds.
REQ-007 bram_raddr = req_addr[g] in cycle T; with no grant it holds its previous value.
REQ-008 A one-stage tag register (valid, id) records the grant at the end of T; in T+1, bram_rdata is captured into rsp_data[id] and rsp_valid[id] is set at the end of T+1.
REQ-009 Latency: request accepted in cycle T gives rsp_valid high in cycle T+2.
REQ-010 rsp_valid[i] and rsp_data[i] are held stable until the cycle with rsp_valid[i] AND rsp_ready[i], after which rsp_valid[i] clears. rsp_ready is ignored while rsp_valid is low.
REQ-011 Each requester has at most one outstanding transaction. A single requester with rsp_ready tied high achieves one grant per 3 cycles (T, T+3, ...).
REQ-012 Different requesters may be granted on consecutive cycles; full throughput is one read per cycle with at least 3 requesters active.
REQ-013 A same-cycle read and write to the same address returns the pre-write data (BRAM read-first); the block provides no forwarding.
REQ-014 req_addr[i] is sampled only in the grant cycle; changes while not granted have no effect.
REQ-015 A requester deasserting req_valid before grant is legal and drops the request; no state is retained.

Reset
REQ-016 During reset:
- req_ready=0, rsp_valid=0, tag valid=0.
- last_grant=N_REQ-1, so requester 0 has first priority.
- bram_raddr=0.
- rsp_data is not reset.
REQ-017 Reset asserted mid-transaction discards all in-flight reads and pending responses. The first grant is possible in the cycle after reset deasserts.

Verification
REQ-018 Single read: preload mem[5]=0xA5A5_0001; req_valid[0]=1, addr 5 at T -> req_ready[0]=1 at T, bram_raddr=5, rsp_valid[0]=1 with rsp_data[0]=0xA5A5_0001 at T+2.
REQ-019 Contention: N_REQ=2, both valid continuously, rsp_ready=1 -> grants are 0,1 on consecutive cycles, then 0 again at T+3, 1 at T+4; never two grants in one cycle.
REQ-020 Backpressure: rsp_ready[1]=0 for 10 cycles after rsp_valid[1] -> rsp_data[1] stable, no further grant to requester 1; requester 0 continues to be served; requester 1 is regranted the cycle after its handshake.
REQ-021 Write/read collision: mem[9]=0x11; wr_valid with addr 9, data 0x22 in the same cycle as the read grant for addr 9 -> response 0x11; next read of addr 9 -> 0x22.
REQ-022 Reset mid-flight: reset asserted at T+1 after a grant at T -> rsp_valid stays 0; after release, requester 0 wins first despite a prior grant to 0.
REQ-023 Random: 3 requesters, random valid/ready/writes, 10k cycles -> every response matches a reference memory model, and no requester waits more than N_REQ grant slots while eligible.
